// File: rtl/disp_pkg.sv
// Shared types and next-digit search for the multiplexed display scan controller.
package disp_pkg;

  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned MAX_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 wrap;
  } next_sel_t;

  // Lowest set mask bit strictly above cur; otherwise the lowest set bit with wrap=1.
  function automatic next_sel_t next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                             input logic [MAX_IDX_W-1:0]  cur);
    next_sel_t            res;
    logic                 found_above;
    logic [MAX_IDX_W-1:0] lowest;
    logic [MAX_IDX_W-1:0] above;
    found_above = 1'b0;
    lowest      = '0;
    above       = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = MAX_IDX_W'(i);
        if (i > int'(cur)) begin
          above       = MAX_IDX_W'(i);
          found_above = 1'b1;
        end
      end
    end
    res.idx  = found_above ? above : lowest;
    res.wrap = ~found_above;
    return res;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/status bundle between the scan controller and its host/segment decoder.
// Optional macro DISP_SCAN_PWM_EN adds the 4-bit brightness input.
interface display_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DWELL_W    = 20
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                  enable;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [DWELL_W-1:0]    dwell;
`ifdef DISP_SCAN_PWM_EN
  logic [3:0]            brightness;
`endif
  logic [NUM_DIGITS-1:0] anode_n;
  logic [IDX_W-1:0]      digit_idx;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output enable, digit_mask, dwell,
`ifdef DISP_SCAN_PWM_EN
    output brightness,
`endif
    input  anode_n, digit_idx, blank, frame_done
  );

  modport slave (
    input  enable, digit_mask, dwell,
`ifdef DISP_SCAN_PWM_EN
    input  brightness,
`endif
    output anode_n, digit_idx, blank, frame_done
  );

endinterface

// File: rtl/digit_next_sel.sv
// Rotating priority finder: next enabled digit above digit_idx, wrapping to the lowest.
module digit_next_sel
  import disp_pkg::*;
#(
  parameter  int unsigned NUM_DIGITS = 8,
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] digit_mask,
  input  logic [IDX_W-1:0]      digit_idx,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  wrap,
  output logic                  any_enabled
);

  next_sel_t sel;
  logic      unused_idx_hi;

  // Search over the full 16-digit space; mask bits above NUM_DIGITS are zero.
  always_comb begin
    sel = next_enabled(MAX_DIGITS'(digit_mask), MAX_IDX_W'(digit_idx));
  end

  assign next_idx      = IDX_W'(sel.idx);
  assign wrap          = sel.wrap;
  assign any_enabled   = |digit_mask;
  // Upper index bits are always zero for narrower configurations.
  assign unused_idx_hi = ^sel.idx;

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: blank gap, per-digit dwell, mask skipping,
// frame_done on wrap. Optional macro DISP_SCAN_PWM_EN adds brightness PWM.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_W      = 20,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  scan_state_e           state;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_DIGITS-1:0] anode_n;
  logic                  blank;
  logic                  frame_done;
  logic [DWELL_W-1:0]    dwell_cnt;
  logic [BLK_W-1:0]      blank_cnt;

  logic [IDX_W-1:0]      sel_cur_c;
  logic [IDX_W-1:0]      next_idx;
  logic                  wrap;
  logic                  any_enabled;
  logic [IDX_W-1:0]      act_idx_c;
  logic [NUM_DIGITS-1:0] act_onehot_c;
  logic [DWELL_W-1:0]    dwell_load_c;
  logic                  adv_c;
  logic                  go_blank_c;
  logic                  go_active_c;
  logic                  lit_entry_c;

`ifdef DISP_SCAN_PWM_EN
  logic [3:0]            pwm_cnt;
  logic [3:0]            pwm_inc_c;
  logic                  lit_stay_c;
  logic [NUM_DIGITS-1:0] cur_onehot_c;
`endif

  // From IDLE, searching above the top index lands on the lowest enabled digit.
  assign sel_cur_c = (state == IDLE) ? IDX_W'(NUM_DIGITS - 1) : digit_idx;

  digit_next_sel #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_next_sel (
    .digit_mask  (bus.digit_mask),
    .digit_idx   (sel_cur_c),
    .next_idx    (next_idx),
    .wrap        (wrap),
    .any_enabled (any_enabled)
  );

  // Advance on IDLE start, dwell expiry, or the lit digit dropping out of the mask.
  assign adv_c = (state == IDLE) ||
                 ((state == ACTIVE) && ((dwell_cnt == '0) || !bus.digit_mask[digit_idx]));
  assign go_blank_c   = adv_c && (BLANK_CYCLES != 0);
  assign go_active_c  = (adv_c && (BLANK_CYCLES == 0)) ||
                        ((state == BLANK) && (blank_cnt == BLK_W'(BLANK_CYCLES - 1)));
  assign act_idx_c    = (state == BLANK) ? digit_idx : next_idx;
  assign act_onehot_c = NUM_DIGITS'(1) << act_idx_c;
  // Dwell counts down to zero; dwell=0 behaves as one cycle.
  assign dwell_load_c = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

`ifdef DISP_SCAN_PWM_EN
  assign pwm_inc_c    = pwm_cnt + 4'(1);
  assign lit_entry_c  = (bus.brightness != 4'd0);
  assign lit_stay_c   = (bus.brightness == 4'hF) || (pwm_inc_c < bus.brightness);
  assign cur_onehot_c = NUM_DIGITS'(1) << digit_idx;
`else
  assign lit_entry_c  = 1'b1;
`endif

  // Scan FSM with registered anode/blank/index/strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      digit_idx  <= '0;
      anode_n    <= '1;
      blank      <= 1'b1;
      frame_done <= 1'b0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
`ifdef DISP_SCAN_PWM_EN
      pwm_cnt    <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (!bus.enable || !any_enabled) begin
        state     <= IDLE;
        anode_n   <= '1;
        blank     <= 1'b1;
        dwell_cnt <= '0;
        blank_cnt <= '0;
`ifdef DISP_SCAN_PWM_EN
        pwm_cnt   <= '0;
`endif
      end else begin
        if (adv_c) begin
          digit_idx  <= next_idx;
          frame_done <= (state == ACTIVE) && wrap;
        end
        if (go_blank_c) begin
          state     <= BLANK;
          anode_n   <= '1;
          blank     <= 1'b1;
          blank_cnt <= '0;
        end else if (go_active_c) begin
          state     <= ACTIVE;
          dwell_cnt <= dwell_load_c;
          anode_n   <= lit_entry_c ? ~act_onehot_c : '1;
          blank     <= ~lit_entry_c;
`ifdef DISP_SCAN_PWM_EN
          pwm_cnt   <= '0;
`endif
        end else if (state == ACTIVE) begin
          dwell_cnt <= dwell_cnt - DWELL_W'(1);
`ifdef DISP_SCAN_PWM_EN
          pwm_cnt   <= pwm_inc_c;
          anode_n   <= lit_stay_c ? ~cur_onehot_c : '1;
          blank     <= ~lit_stay_c;
`endif
        end else if (state == BLANK) begin
          blank_cnt <= blank_cnt + BLK_W'(1);
        end
      end
    end
  end

  assign bus.anode_n    = anode_n;
  assign bus.digit_idx  = digit_idx;
  assign bus.blank      = blank;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: dut_a has a 2-cycle blank gap, dut_b none.
module tb_display_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(ND), .DWELL_W(DW)) ifa ();
  display_scan_ctrl_if #(.NUM_DIGITS(ND), .DWELL_W(DW)) ifb ();

  display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_W(DW), .BLANK_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_W(DW), .BLANK_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL reset_anode got=%b exp=1111", ifa.anode_n); end
    checks++; if (ifa.digit_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", ifa.digit_idx); end
    checks++; if (ifa.blank !== 1'b1) begin errors++; $display("FAIL reset_blank got=%b exp=1", ifa.blank); end
    checks++; if (ifa.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", ifa.frame_done); end
    checks++; if (ifb.anode_n !== 4'b1111) begin errors++; $display("FAIL reset_anode_b got=%b exp=1111", ifb.anode_n); end
    reset = 1'b0;
  endtask

  // mask=1111, dwell=3, blank=2: 2 blank, then per digit 3 lit + 2 blank, 20-cycle frame.
  task automatic test_basic_scan();
    logic [3:0] exp_an;
    logic [1:0] exp_idx;
    logic       exp_fd;
    int         p, d;
    do_reset();
    ifa.digit_mask = 4'b1111;
    ifa.dwell      = 8'd3;
    ifa.enable     = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      tick();
      if (c < 3) begin
        exp_an = 4'b1111; exp_idx = 2'd0; exp_fd = 1'b0;
      end else begin
        p = (c - 3) % 5;
        d = ((c - 3) / 5) % 4;
        if (p < 3) begin
          exp_an  = ~(4'b0001 << d);
          exp_idx = 2'(d);
        end else begin
          exp_an  = 4'b1111;
          exp_idx = 2'((d + 1) % 4);
        end
        exp_fd = ((c - 3) % 20) == 18;
      end
      checks++; if (ifa.anode_n !== exp_an) begin errors++; $display("FAIL basic_anode c=%0d got=%b exp=%b", c, ifa.anode_n, exp_an); end
      checks++; if (ifa.digit_idx !== exp_idx) begin errors++; $display("FAIL basic_idx c=%0d got=%0d exp=%0d", c, ifa.digit_idx, exp_idx); end
      checks++; if (ifa.frame_done !== exp_fd) begin errors++; $display("FAIL basic_fd c=%0d got=%b exp=%b", c, ifa.frame_done, exp_fd); end
      checks++; if (ifa.blank !== (exp_an == 4'b1111)) begin errors++; $display("FAIL basic_blank c=%0d got=%b exp=%b", c, ifa.blank, exp_an == 4'b1111); end
    end
    ifa.enable = 1'b0;
  endtask

  // mask=1010, dwell=2, no blank: digits 1,3 alternate every 2 cycles.
  task automatic test_skip_wrap();
    logic [3:0] exp_an;
    logic [1:0] exp_idx;
    logic       exp_fd;
    int         d;
    do_reset();
    ifb.digit_mask = 4'b1010;
    ifb.dwell      = 8'd2;
    ifb.enable     = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      d       = ((c - 1) / 2) % 2;
      exp_idx = (d == 0) ? 2'd1 : 2'd3;
      exp_an  = (d == 0) ? 4'b1101 : 4'b0111;
      exp_fd  = (c >= 5) && (((c - 1) % 4) == 0);
      checks++; if (ifb.anode_n !== exp_an) begin errors++; $display("FAIL skip_anode c=%0d got=%b exp=%b", c, ifb.anode_n, exp_an); end
      checks++; if (ifb.digit_idx !== exp_idx) begin errors++; $display("FAIL skip_idx c=%0d got=%0d exp=%0d", c, ifb.digit_idx, exp_idx); end
      checks++; if (ifb.frame_done !== exp_fd) begin errors++; $display("FAIL skip_fd c=%0d got=%b exp=%b", c, ifb.frame_done, exp_fd); end
      checks++; if (ifb.blank !== 1'b0) begin errors++; $display("FAIL skip_blank c=%0d got=%b exp=0", c, ifb.blank); end
    end
    ifb.enable = 1'b0;
  endtask

  task automatic test_mask_change();
    do_reset();
    ifa.digit_mask = 4'b1100;
    ifa.dwell      = 8'd100;
    ifa.enable     = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    checks++; if (ifa.anode_n !== 4'b1011) begin errors++; $display("FAIL mask_lit2 got=%b exp=1011", ifa.anode_n); end
    ifa.digit_mask = 4'b1000;
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL mask_off got=%b exp=1111", ifa.anode_n); end
    checks++; if (ifa.digit_idx !== 2'd3) begin errors++; $display("FAIL mask_next_idx got=%0d exp=3", ifa.digit_idx); end
    checks++; if (ifa.frame_done !== 1'b0) begin errors++; $display("FAIL mask_fd got=%b exp=0", ifa.frame_done); end
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL mask_gap got=%b exp=1111", ifa.anode_n); end
    tick();
    checks++; if (ifa.anode_n !== 4'b0111) begin errors++; $display("FAIL mask_lit3 got=%b exp=0111", ifa.anode_n); end
    ifa.digit_mask = 4'b0000;
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL mask_zero_anode got=%b exp=1111", ifa.anode_n); end
    checks++; if (ifa.blank !== 1'b1) begin errors++; $display("FAIL mask_zero_blank got=%b exp=1", ifa.blank); end
    tick();
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL mask_zero_idle got=%b exp=1111", ifa.anode_n); end
    ifa.enable = 1'b0;
  endtask

  task automatic test_enable_reset();
    do_reset();
    ifa.digit_mask = 4'b1111;
    ifa.dwell      = 8'd3;
    ifa.enable     = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    checks++; if (ifa.anode_n !== 4'b1110) begin errors++; $display("FAIL en_lit0 got=%b exp=1110", ifa.anode_n); end
    ifa.enable = 1'b0;
    tick();
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL en_drop_anode got=%b exp=1111", ifa.anode_n); end
    checks++; if (ifa.blank !== 1'b1) begin errors++; $display("FAIL en_drop_blank got=%b exp=1", ifa.blank); end
    checks++; if (ifa.frame_done !== 1'b0) begin errors++; $display("FAIL en_drop_fd got=%b exp=0", ifa.frame_done); end
    ifa.enable = 1'b1;
    tick();
    checks++; if (ifa.digit_idx !== 2'd0 || ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL en_restart got=%0d/%b exp=0/1111", ifa.digit_idx, ifa.anode_n); end
    tick();
    tick();
    checks++; if (ifa.anode_n !== 4'b1110) begin errors++; $display("FAIL en_relit0 got=%b exp=1110", ifa.anode_n); end
    for (int c = 4; c <= 6; c++) tick();
    checks++; if (ifa.digit_idx !== 2'd1 || ifa.blank !== 1'b1) begin errors++; $display("FAIL en_blank1 got=%0d/%b exp=1/1", ifa.digit_idx, ifa.blank); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ifa.digit_idx !== 2'd0) begin errors++; $display("FAIL rst_mid_idx got=%0d exp=0", ifa.digit_idx); end
    checks++; if (ifa.blank !== 1'b1) begin errors++; $display("FAIL rst_mid_blank got=%b exp=1", ifa.blank); end
    checks++; if (ifa.frame_done !== 1'b0) begin errors++; $display("FAIL rst_mid_fd got=%b exp=0", ifa.frame_done); end
    checks++; if (ifa.anode_n !== 4'b1111) begin errors++; $display("FAIL rst_mid_anode got=%b exp=1111", ifa.anode_n); end
    ifa.enable = 1'b0;
  endtask

  task automatic test_dwell_boundary();
    logic [3:0] exp_an;
    logic       exp_fd;
    int         d;
    do_reset();
    ifb.digit_mask = 4'b1111;
    ifb.dwell      = 8'd0;
    ifb.enable     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      d      = (c - 1) % 4;
      exp_an = ~(4'b0001 << d);
      exp_fd = (c == 5) || (c == 9);
      checks++; if (ifb.anode_n !== exp_an) begin errors++; $display("FAIL dwell0_anode c=%0d got=%b exp=%b", c, ifb.anode_n, exp_an); end
      checks++; if (ifb.frame_done !== exp_fd) begin errors++; $display("FAIL dwell0_fd c=%0d got=%b exp=%b", c, ifb.frame_done, exp_fd); end
    end
    do_reset();
    ifb.dwell  = 8'd5;
    ifb.enable = 1'b1;
    tick();
    checks++; if (ifb.anode_n !== 4'b1110) begin errors++; $display("FAIL dwell_chg_c1 got=%b exp=1110", ifb.anode_n); end
    ifb.dwell = 8'd9;
    for (int c = 2; c <= 16; c++) begin
      tick();
      d      = (c <= 5) ? 0 : ((c <= 14) ? 1 : 2);
      exp_an = ~(4'b0001 << d);
      checks++; if (ifb.anode_n !== exp_an) begin errors++; $display("FAIL dwell_chg c=%0d got=%b exp=%b", c, ifb.anode_n, exp_an); end
    end
    ifb.enable = 1'b0;
  endtask

`ifdef DISP_SCAN_PWM_EN
  // Single digit, dwell=32: lit cycles 8/32/0 for brightness 4/15/0; wrap stays at cycle 35.
  task automatic test_pwm();
    logic [3:0] br_v [3];
    int         lit_v [3];
    int         lit;
    br_v  = '{4'd4, 4'd15, 4'd0};
    lit_v = '{8, 32, 0};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      ifa.digit_mask = 4'b0001;
      ifa.dwell      = 8'd32;
      ifa.brightness = br_v[k];
      ifa.enable     = 1'b1;
      lit = 0;
      for (int c = 1; c <= 34; c++) begin
        tick();
        if (ifa.anode_n == 4'b1110) lit++;
      end
      checks++; if (lit != lit_v[k]) begin errors++; $display("FAIL pwm_lit br=%0d got=%0d exp=%0d", br_v[k], lit, lit_v[k]); end
      tick();
      checks++; if (ifa.frame_done !== 1'b1) begin errors++; $display("FAIL pwm_fd br=%0d got=%b exp=1", br_v[k], ifa.frame_done); end
    end
    ifa.brightness = 4'd15;
    ifa.enable     = 1'b0;
  endtask
`endif

  initial begin
    ifa.enable = 1'b0; ifa.digit_mask = '0; ifa.dwell = '0;
    ifb.enable = 1'b0; ifb.digit_mask = '0; ifb.dwell = '0;
`ifdef DISP_SCAN_PWM_EN
    ifa.brightness = 4'd15;
    ifb.brightness = 4'd15;
`endif
    test_reset();
    test_basic_scan();
    test_skip_wrap();
    test_mask_change();
    test_enable_reset();
    test_dwell_boundary();
`ifdef DISP_SCAN_PWM_EN
    test_pwm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller, successor to the fixed free-running anode counter. Cycles through NUM_DIGITS common-anode digits with a programmable per-digit dwell time and an all-off blanking gap between digits to prevent ghosting. Masked-off digits are skipped, and a frame-done strobe is emitted once per full scan. It sits between the system clock domain and the segment decoder, which uses digit_idx to select the digit's segment pattern.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
DWELL_W, 20, width of the dwell input in cycles
BLANK_CYCLES, 64, all-anodes-off cycles between digits (0 = no blanking)
IDX_W, $clog2(NUM_DIGITS), width of digit_idx (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; 0 forces all anodes off
digit_mask  in  NUM_DIGITS  1 = digit participates in scan
dwell  in  DWELL_W  active cycles per digit; sampled on ACTIVE entry
anode_n  out  NUM_DIGITS  active-low one-hot anode drive, registered
digit_idx  out  IDX_W  index of current or next-lit digit, registered
blank  out  1  1 while no anode is driven
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (synchronous, active-high, clock clk): state IDLE; digit_idx=0; anode_n all ones; blank=1; frame_done=0; counters=0. Reset mid-scan takes effect on the next edge with no partial digit.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - If enable=1 and digit_mask!=0, go to BLANK with digit_idx = lowest set mask bit.
  - Otherwise stay in IDLE.
- BLANK:
  - Anodes are off and blank=1 for exactly BLANK_CYCLES cycles, then go to ACTIVE.
  - If BLANK_CYCLES=0, the BLANK state is bypassed: the advance goes straight to ACTIVE.
- ACTIVE:
  - anode_n[digit_idx]=0, all other bits 1; blank=0.
  - Lasts max(dwell,1) cycles; dwell=0 is treated as 1.
  - dwell is latched on entry, so changes mid-dwell apply to the next digit.
- Advance:
  - At the end of ACTIVE, digit_idx moves to the next set mask bit above the current index.
  - If no set bit is above it, digit_idx wraps to the lowest set bit and frame_done pulses in that same cycle.
  - If exactly one digit is enabled, every advance is a wrap, so every advance pulses frame_done.
- Mask handling:
  - The mask is evaluated at each advance.
  - If the current digit's mask bit clears during ACTIVE, ACTIVE ends on the next cycle and an advance occurs.
  - If the mask becomes all-zero at any time, go to IDLE the next cycle with anodes off.
- enable=0 in any state: next cycle IDLE, anodes off, frame_done=0. Re-enabling restarts from the lowest enabled digit via BLANK.
- Output timing: all outputs are registered, so anode_n changes exactly one cycle after the state transition that requests it. Anodes are never driven in two digits in the same cycle.
- Counters: the dwell counter is DWELL_W bits and the blank counter is $clog2(BLANK_CYCLES+1) bits. Neither wraps; both reload on state entry.

Optional Feature:
DISP_SCAN_PWM_EN
- Defined:
  - Adds input brightness[3:0].
  - A 4-bit PWM counter resets on ACTIVE entry and increments each ACTIVE cycle, wrapping 15->0.
  - The anode is asserted only when pwm_cnt < brightness, or when brightness==15 (always on). brightness=0 keeps the anode off, but the dwell still elapses.
  - blank=1 during PWM off-phases.
- Undefined: no brightness port; the anode stays asserted for the full dwell.

Decomposition:
- Shared package disp_pkg: scan_state_e enum (IDLE, BLANK, ACTIVE); function next_enabled(mask, cur) returning index and wrap flag.
- One sub-module, digit_next_sel: a combinational rotating priority finder producing next_idx, wrap and any_enabled from digit_mask and digit_idx. It is instantiated once.

Test Plan:
- Reset/basic scan: NUM_DIGITS=4, mask=4'b1111, dwell=3, BLANK_CYCLES=2 → anode_n sequence 1110×3, 1111×2, 1101×3, … 0111×3. frame_done is a single pulse each 20 cycles, on the wrap to digit 0.
- Skip/wrap: mask=4'b1010, dwell=2, BLANK_CYCLES=0 → digit_idx alternates 1,3,1,3; anode_n toggles 1101/0111 every 2 cycles; frame_done pulses on each 3→1 wrap.
- Mask change mid-dwell: while digit 2 is ACTIVE with dwell=100, clear mask bit 2 → anodes off within 2 cycles, and the next enabled digit is lit after the blank gap. Setting mask=0 → IDLE with anode_n=1111.
- Enable/reset mid-operation: drop enable during ACTIVE → anode_n=all ones next cycle. Asserting reset mid-BLANK → digit_idx=0, blank=1, frame_done=0.
- Boundary dwell: dwell=0 → each digit is lit exactly 1 cycle. Change dwell 5→9 mid-ACTIVE → the current digit still lasts 5 cycles and the next lasts 9.
- PWM (DISP_SCAN_PWM_EN): dwell=32, brightness=4 → 8 lit cycles per digit; brightness=15 → 32; brightness=0 → 0 lit cycles, with scan timing unchanged.
